// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
// keypad_scanner: column-strobed 4x3 keypad scan with full-scan debounce; one key_valid pulse per accepted press.
// Latency: a stable press is accepted within (DEBOUNCE_SCANS+1)*3*SCAN_DIV+2 clocks; release drops key_held after DEBOUNCE_SCANS clean scans.
// Backpressure: none; key_valid is a single-cycle strobe. `define KEYPAD_AUTOREPEAT_EN re-pulses every REPEAT_SCANS held scans.
module keypad_scanner #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_SCANS   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [2:0] columns,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_t;
  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

  // Scan path registers
  logic [DW-1:0] r_div_cnt;
  logic [1:0]    r_col_idx;
  logic [1:0]    r_hit_cnt;   // hits so far this scan, saturating at 2
  logic [3:0]    r_hit_code;
  logic          r_res_vld;
  res_t          r_res_kind;
  logic [3:0]    r_res_code;

  // FSM registers
  state_t        r_state;
  logic [3:0]    r_cand;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_key;
  logic          r_key_valid;
  logic          r_key_held;

  // Combinational next values
  logic          w_sample;
  logic [2:0]    w_slot_hits;
  logic [3:0]    w_slot_code;
  logic [2:0]    w_sum;
  logic [1:0]    w_tot_cnt;
  logic [3:0]    w_tot_code;
  logic          w_is_key;
  state_t        w_state_n;
  logic [3:0]    w_cand_n;
  logic [CW-1:0] w_cnt_n;
  logic [3:0]    w_key_n;
  logic          w_valid_n;
  logic          w_held_n;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_SCANS);
  logic [RW-1:0] r_rpt_cnt;
  logic [RW-1:0] w_rpt_n;
`else
  logic w_unused_rpt;
  assign w_unused_rpt = (REPEAT_SCANS > 0);
`endif

  assign w_sample  = (r_div_cnt == DIV_LAST);
  assign columns   = 3'b001 << r_col_idx;
  assign key       = r_key;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

  assign w_slot_hits = {2'b00, rows[0]} + {2'b00, rows[1]} + {2'b00, rows[2]} + {2'b00, rows[3]};
  assign w_sum       = {1'b0, r_hit_cnt} + w_slot_hits;
  assign w_tot_cnt   = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
  // With exactly one hit per scan, the code comes from whichever slot produced it
  assign w_tot_code  = (w_slot_hits != 3'd0) ? w_slot_code : r_hit_code;
  assign w_is_key    = (r_res_kind == RES_KEY);

  // Decode the (row, driven column) of the current slot into a key code
  always_comb begin
    w_slot_code = 4'd0;
    if (rows[3]) begin
      w_slot_code = 4'd3 - {2'b00, r_col_idx};
    end else if (rows[2]) begin
      w_slot_code = 4'd6 - {2'b00, r_col_idx};
    end else if (rows[1]) begin
      w_slot_code = 4'd9 - {2'b00, r_col_idx};
    end else if (rows[0]) begin
      case (r_col_idx)
        2'd0:    w_slot_code = 4'd11;
        2'd1:    w_slot_code = 4'd0;
        default: w_slot_code = 4'd10;
      endcase
    end
  end

  // Column strobe, per-slot sampling and per-scan result registration
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt  <= '0;
      r_col_idx  <= 2'd0;
      r_hit_cnt  <= 2'd0;
      r_hit_code <= 4'd0;
      r_res_vld  <= 1'b0;
      r_res_kind <= RES_NONE;
      r_res_code <= 4'd0;
    end else begin
      r_res_vld <= 1'b0;
      if (w_sample) begin
        r_div_cnt <= '0;
        if (r_col_idx == 2'd2) begin
          r_col_idx  <= 2'd0;
          r_hit_cnt  <= 2'd0;
          r_hit_code <= 4'd0;
          r_res_vld  <= 1'b1;
          r_res_kind <= (w_tot_cnt == 2'd0) ? RES_NONE :
                        (w_tot_cnt == 2'd1) ? RES_KEY  : RES_MULTI;
          r_res_code <= w_tot_code;
        end else begin
          r_col_idx  <= r_col_idx + 2'd1;
          r_hit_cnt  <= w_tot_cnt;
          r_hit_code <= w_tot_code;
        end
      end else begin
        r_div_cnt <= r_div_cnt + DW'(1);
      end
    end
  end

  // FSM state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cand      <= 4'd0;
      r_cnt       <= '0;
      r_key       <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rpt_cnt   <= '0;
`endif
    end else begin
      r_state     <= w_state_n;
      r_cand      <= w_cand_n;
      r_cnt       <= w_cnt_n;
      r_key       <= w_key_n;
      r_key_valid <= w_valid_n;
      r_key_held  <= w_held_n;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rpt_cnt   <= w_rpt_n;
`endif
    end
  end

  // Debounce FSM: acts only on the cycle after a scan result is registered
  always_comb begin
    w_state_n = r_state;
    w_cand_n  = r_cand;
    w_cnt_n   = r_cnt;
    w_key_n   = r_key;
    w_valid_n = 1'b0;
    w_held_n  = r_key_held;
`ifdef KEYPAD_AUTOREPEAT_EN
    w_rpt_n   = r_rpt_cnt;
`endif
    if (r_res_vld) begin
      case (r_state)
        S_IDLE: begin
          if (w_is_key) begin
            if (DEBOUNCE_SCANS <= 1) begin
              w_state_n = S_PRESSED;
              w_key_n   = r_res_code;
              w_valid_n = 1'b1;
              w_held_n  = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
              w_rpt_n   = '0;
`endif
            end else begin
              w_state_n = S_DEBOUNCE;
              w_cand_n  = r_res_code;
              w_cnt_n   = CW'(1);
            end
          end
        end
        S_DEBOUNCE: begin
          if (w_is_key && (r_res_code == r_cand)) begin
            if (r_cnt + CW'(1) >= DEB_LAST) begin
              w_state_n = S_PRESSED;
              w_key_n   = r_cand;
              w_valid_n = 1'b1;
              w_held_n  = 1'b1;
              w_cnt_n   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              w_rpt_n   = '0;
`endif
            end else begin
              w_cnt_n = r_cnt + CW'(1);
            end
          end else if (w_is_key) begin
            w_cand_n = r_res_code;
            w_cnt_n  = CW'(1);
          end else begin
            w_state_n = S_IDLE;
            w_cnt_n   = '0;
          end
        end
        S_PRESSED: begin
          if (w_is_key && (r_res_code == r_key)) begin
`ifdef KEYPAD_AUTOREPEAT_EN
            if (r_rpt_cnt + RW'(1) >= RPT_LAST) begin
              w_rpt_n   = '0;
              w_valid_n = 1'b1;
            end else begin
              w_rpt_n = r_rpt_cnt + RW'(1);
            end
`endif
          end else if (DEBOUNCE_SCANS <= 1) begin
            w_state_n = S_IDLE;
            w_held_n  = 1'b0;
            w_cnt_n   = '0;
          end else begin
            w_state_n = S_RELEASE;
            w_cnt_n   = CW'(1);
          end
        end
        default: begin
          // Release: the repeat count is left untouched so a bounce back to PRESSED resumes it
          if (w_is_key && (r_res_code == r_key)) begin
            w_state_n = S_PRESSED;
            w_cnt_n   = '0;
          end else if (r_cnt + CW'(1) >= DEB_LAST) begin
            w_state_n = S_IDLE;
            w_held_n  = 1'b0;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n = r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
// tb_keypad_scanner: keypad model driven by columns; expected key pulses queued by stimulus, checked by a monitor.
// Latency: each expectation carries an allowed cycle window for its pulse.
// Backpressure: none; every key_valid pulse must match the head of the queue.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [2:0] columns;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  logic [11:0] pressed = 12'd0;

  typedef struct {
    int code;
    int lo;
    int hi;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   pulse_cnt = 0;
  int   last_pulse_cyc = 0;
  logic prev_vld = 1'b0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3), .REPEAT_SCANS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .columns   (columns),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int krow(input int c);
    if (c == 0 || c == 10 || c == 11) return 0;
    return 3 - (c - 1) / 3;
  endfunction

  function automatic int kcol(input int c);
    if (c == 0) return 1;
    if (c == 10) return 2;
    if (c == 11) return 0;
    return 2 - (c - 1) % 3;
  endfunction

  // Keypad: a pressed key connects its column line to its row line
  always_comb begin
    rows = 4'd0;
    for (int k = 0; k < 12; k++) begin
      if (pressed[k]) rows[krow(k)] = rows[krow(k)] | columns[kcol(k)];
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every key_valid pulse is matched against the next queued expectation
  always @(negedge clk) begin
    if (!reset && key_valid) begin
      exp_t e;
      total++;
      if (prev_vld) begin
        bad++;
        $display("FAIL pulse_width: key_valid high on consecutive cycles at cycle %0d, expected 1-cycle pulse", cyc);
      end
      pulse_cnt++;
      last_pulse_cyc = cyc;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: key=%0d at cycle %0d, expected no pulse", key, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_key", int'(key), e.code);
        total++;
        if (cyc < e.lo || cyc > e.hi) begin
          bad++;
          $display("FAIL pulse_time: key %0d at cycle %0d, expected within [%0d,%0d]", e.code, cyc, e.lo, e.hi);
        end
      end
    end
    prev_vld = key_valid;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input int code, input int lo, input int hi);
    exp_t e;
    e.code = code;
    e.lo   = lo;
    e.hi   = hi;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int limit, input string name);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t0;
    int pc;
    logic held_seen;
    logic [2:0] prev_col;

    // Reset values and column walk
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_columns", int'(columns), 1);
    check("rst_key", int'(key), 0);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_held", int'(key_held), 0);
    reset = 1'b0;
    step(2);
    check("walk_col0", int'(columns), 1);
    step(3);
    check("walk_col1", int'(columns), 2);
    step(4);
    check("walk_col2", int'(columns), 4);
    step(4);
    check("walk_wrap", int'(columns), 1);

    // Key 5 held: one pulse, key_held until release, key retained after
    pressed = 12'd1 << 5;
    expect_pulse(5, cyc, cyc + 50);
    wait_drain(60, "drain_key5");
    step(20);
    check("held_key5", int'(key_held), 1);
    check("key_is_5", int'(key), 5);
    pressed = 12'd0;
    step(60);
    check("released_key5", int'(key_held), 0);
    check("key5_retained", int'(key), 5);

    // Key 8 bouncing at the scan rate never debounces
    pc = pulse_cnt;
    held_seen = 1'b0;
    for (int t = 0; t < 16; t++) begin
      pressed = t[0] ? 12'd0 : (12'd1 << 8);
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        held_seen = held_seen | key_held;
      end
    end
    pressed = 12'd0;
    step(40);
    check("bounce_no_held", int'(held_seen), 0);
    check("bounce_no_pulse", pulse_cnt - pc, 0);

    // Ghosted pair 1+9 is rejected; releasing 9 accepts 1
    pc = pulse_cnt;
    pressed = (12'd1 << 1) | (12'd1 << 9);
    step(100);
    check("multi_no_pulse", pulse_cnt - pc, 0);
    check("multi_no_held", int'(key_held), 0);
    pressed = 12'd1 << 1;
    expect_pulse(1, cyc, cyc + 50);
    wait_drain(60, "drain_key1");
    check("held_key1", int'(key_held), 1);
    pressed = 12'd0;
    step(60);

    // '#' press, release aligned to a scan boundary, then '*'
    pressed = 12'd1 << 11;
    expect_pulse(11, cyc, cyc + 50);
    wait_drain(60, "drain_key11");
    prev_col = columns;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (columns == 3'b001 && prev_col == 3'b100) break;
      prev_col = columns;
    end
    pressed = 12'd0;
    n = 0;
    while (key_held && n < 80) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n < 34 || n > 38) begin
      bad++;
      $display("FAIL release_time: key_held fell after %0d clocks, expected 34..38", n);
    end
    pressed = 12'd1 << 10;
    expect_pulse(10, cyc, cyc + 50);
    wait_drain(60, "drain_key10");
    check("key_is_10", int'(key), 10);
    pressed = 12'd0;
    step(60);

    // Reset during debounce of key 4 discards it
    pc = pulse_cnt;
    pressed = 12'd1 << 4;
    step(20);
    reset = 1'b1;
    pressed = 12'd0;
    step(3);
    reset = 1'b0;
    check("midrst_key", int'(key), 0);
    check("midrst_held", int'(key_held), 0);
    check("midrst_columns", int'(columns), 1);
    step(80);
    check("midrst_no_pulse", pulse_cnt - pc, 0);

`ifdef KEYPAD_AUTOREPEAT_EN
    // Held key 2 repeats every 4 scans of 12 clocks
    pressed = 12'd1 << 2;
    expect_pulse(2, cyc, cyc + 50);
    wait_drain(60, "drain_key2");
    t0 = last_pulse_cyc;
    expect_pulse(2, t0 + 48, t0 + 48);
    wait_drain(60, "drain_rpt1");
    expect_pulse(2, t0 + 96, t0 + 96);
    wait_drain(60, "drain_rpt2");
    pressed = 12'd0;
    step(60);
`else
    // Long hold of key 2 still produces exactly one pulse
    pc = pulse_cnt;
    pressed = 12'd1 << 2;
    expect_pulse(2, cyc, cyc + 50);
    wait_drain(60, "drain_key2");
    t0 = last_pulse_cyc;
    step(150);
    check("no_repeat", pulse_cnt - pc, 1);
    check("held_key2", int'(key_held), 1);
    pressed = 12'd0;
    step(60);
`endif
    check("final_queue_empty", exp_q.size(), 0);
    check("final_held", int'(key_held), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
